cp0_exc_ctrl: RTL

Exception sequencer that drives the CP0 register file's exception-side inputs. It samples decoded trap/return requests and an external interrupt line, and checks them against the CP0 status word. It issues single-cycle exception commit (`exc_w`, `cause`, `pc_out`) or return (`ret_w`) pulses toward CP0, then redirects the fetch PC to the handler or to EPC. It sits between the instruction decoder and CP0 and stalls the datapath for the two cycles of each sequence.

---
 rtl/cp0_exc_ctrl.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/cp0_exc_ctrl.sv
`timescale 1ns/1ps
// cp0_exc_ctrl
// Exception sequencer between the instruction decoder and the CP0 register
// file. Accepts one trap / eret / interrupt per IDLE cycle, then runs a
// two-cycle sequence: a commit pulse toward CP0 (exc_w or ret_w), followed
// by a fetch redirect to the handler or to EPC. stall covers both cycles.
//
// Ports:
//   clk, rst                    rising-edge clock, async active-high reset
//   syscall_req, break_req,
//   teq_req, eret_req           one-cycle decoder request pulses
//   int_in                      external interrupt level (asynchronous)
//   instr_pc                    PC of the instruction in execute
//   status, epc                 CP0 status (reg 12) and EPC (reg 14)
//   exc_w, cause, pc_out        exception commit pulse, cause code, EPC value
//   ret_w                       return pulse to CP0
//   redirect, redirect_pc       fetch redirect pulse and target
//   stall                       sequence in progress
module cp0_exc_ctrl #(
   parameter logic [31:0] HANDLER_PC = 32'h0040_0004,
   parameter logic [4:0]  CAUSE_SYS  = 5'd8,
   parameter logic [4:0]  CAUSE_BRK  = 5'd9,
   parameter logic [4:0]  CAUSE_TEQ  = 5'd13,
   parameter logic [4:0]  CAUSE_INT  = 5'd0
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        syscall_req,
   input  logic        break_req,
   input  logic        teq_req,
   input  logic        eret_req,
   input  logic        int_in,
   input  logic [31:0] instr_pc,
   input  logic [31:0] status,
   input  logic [31:0] epc,
   output logic        exc_w,
   output logic        ret_w,
   output logic [4:0]  cause,
   output logic [31:0] pc_out,
   output logic        redirect,
   output logic [31:0] redirect_pc,
   output logic        stall
);

   typedef enum logic [1:0] {IDLE, EXC, RET, REDIR} state_t;

   state_t      state_reg, state_next;
   logic        int_sync1_reg, int_sync2_reg, int_sync2_d_reg;
   logic        int_pend_reg, int_pend_next;
   logic        int_rise, take_int;
   logic        exc_w_reg, ret_w_reg, redirect_reg, stall_reg;
   logic [4:0]  cause_reg, cause_next;
   logic [31:0] pc_out_reg, pc_out_next;
   logic [31:0] redirect_pc_reg, redirect_pc_next;
   logic        ie, sys_en, brk_en, teq_en, int_en;
   logic        unused_status;

   // Only IE and the four per-source enable bits are meaningful here.
   assign unused_status = ^{status[31:12], status[7:1]};

   assign ie     = status[0];
   assign sys_en = syscall_req & ie & status[8];
   assign brk_en = break_req   & ie & status[9];
   assign teq_en = teq_req     & ie & status[10];
   assign int_en = int_pend_reg & ie & status[11];

   // Edge detect on the synchronized level; a held-high line posts only once.
   assign int_rise = int_sync2_reg & ~int_sync2_d_reg;

   always_comb begin
      state_next       = state_reg;
      cause_next       = cause_reg;
      pc_out_next      = pc_out_reg;
      redirect_pc_next = redirect_pc_reg;
      take_int         = 1'b0;
      case (state_reg)
         IDLE: begin
            // Disabled traps fall through to lower-priority sources.
            if (sys_en) begin
               cause_next  = CAUSE_SYS;
               pc_out_next = instr_pc;
               state_next  = EXC;
            end else if (brk_en) begin
               cause_next  = CAUSE_BRK;
               pc_out_next = instr_pc;
               state_next  = EXC;
            end else if (teq_en) begin
               cause_next  = CAUSE_TEQ;
               pc_out_next = instr_pc;
               state_next  = EXC;
            end else if (eret_req) begin
               state_next  = RET;
            end else if (int_en) begin
               // Interrupted instruction restarts, so EPC is its own PC.
               cause_next  = CAUSE_INT;
               pc_out_next = instr_pc;
               state_next  = EXC;
               take_int    = 1'b1;
            end
         end
         EXC: begin
            redirect_pc_next = HANDLER_PC;
            state_next       = REDIR;
         end
         RET: begin
            redirect_pc_next = epc;
            state_next       = REDIR;
         end
         REDIR:   state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_comb begin
      int_pend_next = int_pend_reg;
      if (take_int) int_pend_next = 1'b0;
      if (int_rise) int_pend_next = 1'b1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg       <= IDLE;
         int_sync1_reg   <= 1'b0;
         int_sync2_reg   <= 1'b0;
         int_sync2_d_reg <= 1'b0;
         int_pend_reg    <= 1'b0;
         exc_w_reg       <= 1'b0;
         ret_w_reg       <= 1'b0;
         redirect_reg    <= 1'b0;
         stall_reg       <= 1'b0;
         cause_reg       <= 5'd0;
         pc_out_reg      <= 32'd0;
         redirect_pc_reg <= 32'd0;
      end else begin
         state_reg       <= state_next;
         int_sync1_reg   <= int_in;
         int_sync2_reg   <= int_sync1_reg;
         int_sync2_d_reg <= int_sync2_reg;
         int_pend_reg    <= int_pend_next;
         // Pulses are decoded from the next state so they line up with it.
         exc_w_reg       <= (state_next == EXC);
         ret_w_reg       <= (state_next == RET);
         redirect_reg    <= (state_next == REDIR);
         stall_reg       <= (state_next != IDLE);
         cause_reg       <= cause_next;
         pc_out_reg      <= pc_out_next;
         redirect_pc_reg <= redirect_pc_next;
      end
   end

   assign exc_w       = exc_w_reg;
   assign ret_w       = ret_w_reg;
   assign redirect    = redirect_reg;
   assign stall       = stall_reg;
   assign cause       = cause_reg;
   assign pc_out      = pc_out_reg;
   assign redirect_pc = redirect_pc_reg;

endmodule
